// File: rtl/cic_pkg.sv
// Shared CIC helpers: rate-to-shift lookup, accumulator width and output clamp.
// Used by both the interpolating and the decimating CIC blocks.
package cic_pkg;

  localparam int CIC_Q_MIN = 1;
  localparam int CIC_Q_MAX = 6;

  // Returns -1 for unsupported rates so the instantiating module can stop elaboration.
  function automatic int cic_log2(input int r);
    case (r)
      1:       return 0;
      2:       return 1;
      4:       return 2;
      8:       return 3;
      16:      return 4;
      default: return -1;
    endcase
  endfunction

  function automatic int cic_acc_width(input int dw, input int q, input int r);
    return dw + q * cic_log2(r);
  endfunction

  function automatic longint cic_sat(input longint v, input int dw);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (dw - 1)) - 1;
    lo = -(longint'(1) <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cic_int_stage.sv
// One CIC integrator: an enabled, wrapping two's complement accumulator.
module cic_int_stage #(
  parameter int ACC_W = 19
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic signed [ACC_W-1:0] in_i,
  output logic signed [ACC_W-1:0] out_o
);

  logic signed [ACC_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (en_i) acc_d = acc_q + in_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign out_o = acc_q;

endmodule

// File: rtl/cic_interpolator.sv
// Q-stage CIC interpolator: low-rate combs, zero-stuff by R, high-rate integrators,
// gain-normalised and saturated output every CLK_DIV clocks. Single clock domain.
module cic_interpolator
  import cic_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int Q          = 3,
  parameter int R          = 2,
  parameter int CLK_DIV    = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] x_out,
  output logic                         underrun
);

  localparam int LOG2_R = cic_log2(R);
  localparam int ACC_W  = cic_acc_width(DATA_WIDTH, Q, R);
  localparam int SHIFT  = (Q - 1) * LOG2_R;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PH_W   = (LOG2_R > 0) ? LOG2_R : 1;

  if (LOG2_R < 0) begin : g_bad_r
    $error("cic_interpolator: R must be 1, 2, 4, 8 or 16");
  end
  if (Q < CIC_Q_MIN || Q > CIC_Q_MAX || CLK_DIV < 1) begin : g_bad_cfg
    $error("cic_interpolator: Q must be 1..6 and CLK_DIV >= 1");
  end

  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic signed [ACC_W-1:0] hold_q, hold_d;
  logic                    hold_full_q, hold_full_d;
  logic signed [DATA_WIDTH-1:0] x_out_q, x_out_d;
  logic                    out_valid_q;
  logic signed [ACC_W-1:0] z_q [Q];
  logic signed [ACC_W-1:0] c [Q];
  logic signed [ACC_W-1:0] integ [Q];
  logic signed [ACC_W-1:0] hold_val, u, shifted;
  logic                    tick, slot, accept;

  assign tick     = (div_cnt_q == DIV_W'(CLK_DIV - 1));
  assign slot     = tick && (phase_q == '0);
  assign in_ready = !hold_full_q || slot;
  assign accept   = in_valid && in_ready;
  assign underrun = slot && !hold_full_q;
  assign hold_val = hold_full_q ? hold_q : '0;

  always_comb begin
    div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
    phase_d     = phase_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (tick) phase_d = (phase_q == PH_W'(R - 1)) ? '0 : phase_q + 1'b1;
    // An accept in a slot cycle refills the register the comb is emptying.
    if (accept) begin
      hold_d      = ACC_W'(x_in);
      hold_full_d = 1'b1;
    end else if (slot) begin
      hold_full_d = 1'b0;
    end
  end

  always_comb begin
    c[0] = hold_val - z_q[0];
    for (int i = 1; i < Q; i++) c[i] = c[i-1] - z_q[i];
  end

  assign u       = slot ? c[Q-1] : '0;
  assign shifted = integ[Q-1] >>> SHIFT;
  assign x_out_d = DATA_WIDTH'(cic_sat(64'(shifted), DATA_WIDTH));

  for (genvar k = 0; k < Q; k++) begin : g_int
    logic signed [ACC_W-1:0] stage_in;
    if (k == 0) begin : g_first
      assign stage_in = u;
    end else begin : g_next
      assign stage_in = integ[k-1];
    end
    cic_int_stage #(.ACC_W(ACC_W)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (tick),
      .in_i  (stage_in),
      .out_o (integ[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q   <= '0;
      phase_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      x_out_q     <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < Q; i++) z_q[i] <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      out_valid_q <= tick;
      if (tick) x_out_q <= x_out_d;
      if (slot) begin
        z_q[0] <= hold_val;
        for (int i = 1; i < Q; i++) z_q[i] <= c[i-1];
      end
    end
  end

  assign x_out     = x_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench for cic_interpolator with a tick-level reference model feeding
// an expected-output queue, plus direct checks of the documented waveforms.
module tb_cic_interpolator;

  localparam int DW    = 16;
  localparam int Q     = 3;
  localparam int R     = 2;
  localparam int CD    = 3;
  localparam int ACC_W = DW + Q * 1;
  localparam int SHIFT = (Q - 1) * 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] x_in;
  logic                 out_valid;
  logic signed [DW-1:0] x_out;
  logic                 underrun;

  int n_cmp = 0;
  int n_bad = 0;

  cic_interpolator #(.DATA_WIDTH(DW), .Q(Q), .R(R), .CLK_DIV(CD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .out_valid (out_valid),
    .x_out     (x_out),
    .underrun  (underrun)
  );

  always #27 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int binom(input int n, input int k);
    int b = 1;
    for (int i = 0; i < k; i++) b = b * (n - i) / (i + 1);
    return b;
  endfunction

  function automatic logic signed [DW-1:0] bsat(input logic signed [ACC_W-1:0] v);
    longint lv = v;
    if (lv > 32767)  return 16'sd32767;
    if (lv < -32768) return -16'sd32768;
    return DW'(lv);
  endfunction

  // Reference model: comb stages as a binomial difference over consumed samples.
  logic signed [ACC_W-1:0] m_hist [Q+1];
  logic signed [ACC_W-1:0] m_i [Q];
  logic signed [ACC_W-1:0] m_hold;
  logic signed [ACC_W-1:0] m_u;
  logic signed [63:0]      m_sum;
  bit                      m_full, m_ov, m_tick, m_slot, m_acc;
  int                      m_div, m_phase;
  logic signed [DW-1:0]    exp_q [$];
  logic signed [DW-1:0]    obs_q [$];

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int j = 0; j <= Q; j++) m_hist[j] = '0;
        for (int k = 0; k < Q; k++) m_i[k] = '0;
        m_hold = '0; m_full = 0; m_ov = 0; m_div = 0; m_phase = 0;
        exp_q.delete();
      end else begin
        m_tick = (m_div == CD - 1);
        m_slot = m_tick && (m_phase == 0);
        m_acc  = in_valid && (!m_full || m_slot);
        m_u    = '0;
        if (m_slot) begin
          for (int j = Q; j > 0; j--) m_hist[j] = m_hist[j-1];
          m_hist[0] = m_full ? m_hold : '0;
          m_sum = 0;
          for (int j = 0; j <= Q; j++)
            m_sum = (j % 2 == 0) ? m_sum + binom(Q, j) * m_hist[j] : m_sum - binom(Q, j) * m_hist[j];
          m_u = ACC_W'(m_sum);
        end
        if (m_tick) begin
          exp_q.push_back(bsat(m_i[Q-1] >>> SHIFT));
          for (int k = Q - 1; k > 0; k--) m_i[k] = m_i[k] + m_i[k-1];
          m_i[0] = m_i[0] + m_u;
          m_phase = (m_phase == R - 1) ? 0 : m_phase + 1;
        end
        m_ov = m_tick;
        if (m_acc) begin
          m_hold = ACC_W'(x_in);
          m_full = 1;
        end else if (m_slot) begin
          m_full = 0;
        end
        m_div = (m_div == CD - 1) ? 0 : m_div + 1;
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial begin
    logic signed [DW-1:0] e;
    bit s;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        s = (m_div == CD - 1) && (m_phase == 0);
        chk("in_ready", in_ready, !m_full || s);
        chk("underrun", underrun, s && !m_full);
        chk("out_valid", out_valid, m_ov);
        if (out_valid === 1'b1) obs_q.push_back(x_out);
        if (m_ov && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("x_out", x_out, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
  endtask

  initial begin
    int ov_cnt, ur_cnt, nz_cnt, stall, pos_cnt;
    int imp_exp [8] = '{0, 0, 0, 16, 48, 48, 16, 0};

    rst_n = 1'b0; in_valid = 1'b0; x_in = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_x_out", x_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_underrun", underrun, 0);

    // Idle after release: output ticks every 3 clocks, empty slots every 6.
    rst_n = 1'b1;
    ov_cnt = 0; ur_cnt = 0; nz_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      ov_cnt += int'(out_valid === 1'b1);
      ur_cnt += int'(underrun === 1'b1);
      nz_cnt += int'(x_out !== 0);
    end
    chk("idle_out_valid_count", ov_cnt, 10);
    chk("idle_underrun_count", ur_cnt, 5);
    chk("idle_x_out_nonzero", nz_cnt, 0);

    // Impulse of 64 ahead of the first slot, zeros afterwards.
    do_reset();
    in_valid = 1'b1; x_in = 16'sd64;
    @(negedge clk);
    x_in = '0;
    repeat (40) @(negedge clk);
    in_valid = 1'b0;
    chk("imp_len_ok", obs_q.size() >= 8, 1);
    if (obs_q.size() >= 8)
      for (int i = 0; i < 8; i++) chk($sformatf("imp_%0d", i), obs_q[i], imp_exp[i]);

    // DC input held valid continuously.
    do_reset();
    in_valid = 1'b1; x_in = 16'sd100;
    ur_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      ur_cnt += int'(underrun === 1'b1);
    end
    chk("dc_underrun_count", ur_cnt, 0);
    chk("dc_len_ok", obs_q.size() >= 10, 1);
    if (obs_q.size() >= 10)
      for (int i = obs_q.size() - 5; i < obs_q.size(); i++) chk("dc_settled", obs_q[i], 100);

    // Full-scale negative DC.
    do_reset();
    in_valid = 1'b1; x_in = -16'sd32768;
    repeat (60) @(negedge clk);
    pos_cnt = 0;
    foreach (obs_q[i]) pos_cnt += int'(obs_q[i] > 0);
    chk("neg_no_sign_flip", pos_cnt, 0);
    chk("neg_len_ok", obs_q.size() >= 10, 1);
    if (obs_q.size() >= 10)
      for (int i = obs_q.size() - 5; i < obs_q.size(); i++) chk("neg_settled", obs_q[i], -32768);
    in_valid = 1'b0;

    // Handshake: two samples back to back between slots; second stalls until the slot.
    do_reset();
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    in_valid = 1'b1; x_in = 16'sd1000;
    @(negedge clk);
    x_in = -16'sd500;
    chk("hs_second_stalled", in_ready, 0);
    stall = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready === 1'b1) break;
      stall++;
      @(negedge clk);
    end
    chk("hs_stall_cycles", stall, 4);
    chk("hs_accept_in_slot", underrun, 0);
    @(negedge clk);
    in_valid = 1'b0; x_in = '0;
    repeat (60) @(negedge clk);

    // Asynchronous reset in the middle of an impulse response.
    do_reset();
    in_valid = 1'b1; x_in = 16'sd64;
    @(negedge clk);
    x_in = '0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1 && x_out == 16'sd48) break;
      @(negedge clk);
    end
    chk("mid_pre_value", x_out, 48);
    #5 rst_n = 1'b0;
    #1;
    chk("mid_rst_x_out", x_out, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
    repeat (40) @(negedge clk);
    nz_cnt = 0;
    foreach (obs_q[i]) nz_cnt += int'(obs_q[i] != 0);
    chk("mid_no_tail", nz_cnt, 0);
    chk("mid_outputs_seen", obs_q.size() >= 10, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
